spi_reg_target: RTL and testbench
=================================

Name: spi_reg_target

Overview:
- SPI target (peripheral) end of the link driven by the board's SPI driver; it is the responder for that block's write and read transactions.
- Oversamples `spi_clk` and `serial_in` on the system clock, decodes a command/address byte, then either writes a burst into an internal register bank or shifts register contents back out.
- Used on-board as the loopback/emulation target and as the register front-end for FPGA-side peripherals.

Parameters:
- REG_WIDTH, 8, data bits per register and per SPI byte; only 8 is supported.
- NUM_REGS, 16, number of registers implemented (1..128); addresses >= NUM_REGS are out of range.
- IDLE_TIMEOUT, 64, `clk` cycles without any `spi_clk` edge that end a frame.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- spi_clk  input  1  SPI clock from the initiator; idle low, mode 0
- serial_in  input  1  initiator-to-target data (MOSI)
- serial_out  output  1  target-to-initiator data (MISO)
- regs_out  output  NUM_REGS*REG_WIDTH  flattened register bank; reg[i] is bits [i*8+7:i*8]
- wr_strobe  output  1  one-cycle pulse per committed register write
- wr_addr  output  7  address of the last committed write
- busy  output  1  high while a frame is in progress (state != IDLE)
- frame_error  output  1  one-cycle pulse when a frame ends with a partial byte

Behaviour:
- Reset and clocking:
  - One clock (`clk`); reset is asynchronous, active-low (`rstn`).
  - On reset: serial_out=0, regs_out=0, wr_strobe=0, wr_addr=0, busy=0, frame_error=0, state=IDLE, bit counter=0, both shift registers=0.
  - Reset asserted mid-frame aborts the frame immediately; no partial write is committed.
- Input synchronisation and edge detection:
  - `spi_clk` and `serial_in` each pass through a 2-flop synchroniser.
  - "Rise" is a cycle in which synced `spi_clk` goes 0->1; "fall" is 1->0.
  - Required timing: `spi_clk` high and low phases are each >= 4 `clk` cycles.
- Bit and byte rules:
  - Synced `serial_in` is sampled on each rise, MSB first.
  - A 3-bit counter counts sampled bits; every 8th rise completes a byte.
- Command byte (first byte of a frame): bit7 = rw (1=write, 0=read); bits[6:0] = start address.
- States and transitions:
  - IDLE -> CMD on the first rise.
  - CMD -> WR_DATA (rw=1) or RD_DATA (rw=0) on the 8th rise of the command byte.
  - WR_DATA: on each completed byte, if addr < NUM_REGS, reg[addr] is updated and wr_strobe and wr_addr are driven in the cycle after the rise, so the new value is visible 1 `clk` after detection. If addr >= NUM_REGS, the byte is dropped and no strobe is issued. The address then advances.
  - RD_DATA:
    - Load: on the 8th rise of each byte (including the command byte), load the TX shift register with reg[addr] (0x00 if out of range), then advance the address.
    - Shift-out: serial_out presents the TX MSB on the following fall and shifts one bit on each subsequent fall.
    - Input: bits arriving on serial_in during RD_DATA are ignored.
  - serial_out = 0 in IDLE, CMD and WR_DATA.
- Address advance: 7-bit increment, wrapping 127 -> 0.
- Frame end (idle timeout):
  - Counter cleared on every rise or fall; when it reaches IDLE_TIMEOUT in a non-IDLE state -> IDLE.
  - If bit counter != 0 at that point, frame_error pulses for 1 cycle and the partial byte is discarded.
  - Counter saturates and does not run in IDLE.
- Simultaneous events: a timeout cannot coincide with an edge, because any edge clears the counter first. A write commit and the timeout check in the same cycle resolve as commit first, then return to IDLE.

Optional Feature:
- Macro: SPI_REG_TARGET_AUTOINC_EN.
- Defined: the address auto-increments after each data byte, as described above.
- Undefined: the address stays fixed for the whole frame. A burst write overwrites the same register repeatedly (one wr_strobe per byte); a burst read returns the same register repeatedly.

Test Plan:
- Single write: frame 0x85, 0xA5 -> reg5=0xA5; exactly one wr_strobe with wr_addr=5; busy drops IDLE_TIMEOUT cycles after the last edge.
- Burst write, NUM_REGS=16: frame 0x8E, 0x11, 0x22, 0x33 -> reg14=0x11, reg15=0x22; the third byte (addr 16) is dropped; exactly 2 strobes.
- Read after write: preload reg5=0xA5, reg6=0x3C; frame 0x05 plus 16 clocks -> initiator samples 0xA5 then 0x3C on rises; registers unchanged; no strobe.
- Out-of-range read: frame 0x7F plus 8 clocks -> returns 0x00; with AUTOINC the address wraps and the next byte returns reg0.
- Partial frame: 3 clocks then idle -> frame_error pulses once after IDLE_TIMEOUT; a following full write frame 0x81, 0x5A sets reg1=0x5A.
- Reset mid-write: assert rstn low after 5 bits of the data byte -> all regs_out=0 and serial_out=0 immediately; no strobe; the next frame works.

Source files
------------

// File: rtl/spi_reg_target.sv
// SPI mode-0 target: oversampled front end, command/address decode, register bank.
// Burst address auto-increment is enabled by defining SPI_REG_TARGET_AUTOINC_EN.
module spi_reg_target #(
  parameter int REG_WIDTH    = 8,
  parameter int NUM_REGS     = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          spi_clk,
  input  logic                          serial_in,
  output logic                          serial_out,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs_out,
  output logic                          wr_strobe,
  output logic [6:0]                    wr_addr,
  output logic                          busy,
  output logic                          frame_error
);

  // state   | meaning
  // IDLE    | no frame in progress, waiting for the first spi_clk rise
  // CMD     | shifting in the command/address byte
  // WR_DATA | shifting in data bytes and committing them to registers
  // RD_DATA | shifting register contents out on serial_out
  typedef enum logic [1:0] {IDLE, CMD, WR_DATA, RD_DATA} state_t;

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  state_t                                 state_q, state_d;
  logic [1:0]                             sclk_sync_q, sclk_sync_d;
  logic                                   sclk_prev_q, sclk_prev_d;
  logic [1:0]                             sin_sync_q, sin_sync_d;
  logic [2:0]                             bit_cnt_q, bit_cnt_d;
  logic [REG_WIDTH-2:0]                   rx_sr_q, rx_sr_d;
  logic [REG_WIDTH-1:0]                   tx_sr_q, tx_sr_d;
  logic [6:0]                             addr_q, addr_d;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0]     regs_q, regs_d;
  logic                                   serial_out_q, serial_out_d;
  logic                                   wr_strobe_q, wr_strobe_d;
  logic [6:0]                             wr_addr_q, wr_addr_d;
  logic                                   frame_error_q, frame_error_d;
  logic [TW-1:0]                          tmr_q, tmr_d;

  logic                 rise, fall, sin, byte_done;
  logic [REG_WIDTH-1:0] rx_byte;
  logic [6:0]           addr_step;

`ifdef SPI_REG_TARGET_AUTOINC_EN
  assign addr_step = 7'd1;
`else
  assign addr_step = 7'd0;
`endif

  assign rise      = sclk_sync_q[1] & ~sclk_prev_q;
  assign fall      = ~sclk_sync_q[1] & sclk_prev_q;
  assign sin       = sin_sync_q[1];
  assign rx_byte   = {rx_sr_q, sin};
  assign byte_done = rise && (bit_cnt_q == 3'd7);

  // Out-of-range addresses read back as zero.
  function automatic logic [REG_WIDTH-1:0] reg_at(
    input logic [NUM_REGS-1:0][REG_WIDTH-1:0] r,
    input logic [6:0]                         a
  );
    logic [REG_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == 7'(i)) v = r[i];
    end
    return v;
  endfunction

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[0], spi_clk};
    sclk_prev_d   = sclk_sync_q[1];
    sin_sync_d    = {sin_sync_q[0], serial_in};
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    addr_d        = addr_q;
    regs_d        = regs_q;
    serial_out_d  = serial_out_q;
    wr_strobe_d   = 1'b0;
    wr_addr_d     = wr_addr_q;
    frame_error_d = 1'b0;
    tmr_d         = tmr_q;

    if (rise || fall) tmr_d = TW'(IDLE_TIMEOUT);
    else if (tmr_q != '0) tmr_d = tmr_q - TW'(1);

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = CMD;
          bit_cnt_d = 3'd1;
          rx_sr_d   = rx_byte[REG_WIDTH-2:0];
        end else begin
          tmr_d = '0;
        end
      end
      CMD: begin
        if (rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          rx_sr_d   = rx_byte[REG_WIDTH-2:0];
          if (byte_done) begin
            if (rx_byte[7]) begin
              state_d = WR_DATA;
              addr_d  = rx_byte[6:0];
            end else begin
              state_d = RD_DATA;
              tx_sr_d = reg_at(regs_q, rx_byte[6:0]);
              addr_d  = rx_byte[6:0] + addr_step;
            end
          end
        end
      end
      WR_DATA: begin
        if (rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          rx_sr_d   = rx_byte[REG_WIDTH-2:0];
          if (byte_done) begin
            if (int'(addr_q) < NUM_REGS) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
              if (addr_q == 7'(i)) regs_d[i] = rx_byte;
            end
            addr_d = addr_q + addr_step;
          end
        end
      end
      RD_DATA: begin
        // serial_in is ignored here; only the bit count matters.
        if (rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) begin
            tx_sr_d = reg_at(regs_q, addr_q);
            addr_d  = addr_q + addr_step;
          end
        end else if (fall) begin
          serial_out_d = tx_sr_q[REG_WIDTH-1];
          tx_sr_d      = {tx_sr_q[REG_WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    // Edges reload the timer, so expiry never coincides with a commit.
    if (state_q != IDLE && !rise && !fall && tmr_q == TW'(1)) begin
      state_d       = IDLE;
      bit_cnt_d     = 3'd0;
      rx_sr_d       = '0;
      tx_sr_d       = '0;
      frame_error_d = (bit_cnt_q != 3'd0);
    end

    if (state_d != RD_DATA) serial_out_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      sclk_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      sin_sync_q    <= '0;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      addr_q        <= '0;
      regs_q        <= '0;
      serial_out_q  <= 1'b0;
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= '0;
      frame_error_q <= 1'b0;
      tmr_q         <= '0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      sin_sync_q    <= sin_sync_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      addr_q        <= addr_d;
      regs_q        <= regs_d;
      serial_out_q  <= serial_out_d;
      wr_strobe_q   <= wr_strobe_d;
      wr_addr_q     <= wr_addr_d;
      frame_error_q <= frame_error_d;
      tmr_q         <= tmr_d;
    end
  end

  assign serial_out  = serial_out_q;
  assign regs_out    = regs_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign busy        = (state_q != IDLE);
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_reg_target.sv
// Self-checking bench for spi_reg_target: directed vector table, hand-written corner
// sequences and random frames against a byte-level register-bank model.
module tb_spi_reg_target;

  localparam int NR   = 16;
  localparam int IT   = 64;
  localparam int HALF = 6;
`ifdef SPI_REG_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn;
  logic            spi_clk;
  logic            serial_in;
  logic            serial_out;
  logic [NR*8-1:0] regs_out;
  logic            wr_strobe;
  logic [6:0]      wr_addr;
  logic            busy;
  logic            frame_error;

  spi_reg_target #(.REG_WIDTH(8), .NUM_REGS(NR), .IDLE_TIMEOUT(IT)) dut (
    .clk(clk), .rstn(rstn), .spi_clk(spi_clk), .serial_in(serial_in),
    .serial_out(serial_out), .regs_out(regs_out), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .busy(busy), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int strobe_cnt = 0;
  int ferr_cnt   = 0;

  always @(negedge clk) begin
    if (wr_strobe)   strobe_cnt++;
    if (frame_error) ferr_cnt++;
  end

  logic [7:0] m_regs [NR];
  logic [6:0] m_waddr;

  typedef struct {
    logic [31:0] frame;
    int          n;
    int          strb;
    int          c1_idx;
    logic [7:0]  c1_val;
    int          c2_idx;
    logic [7:0]  c2_val;
    logic [31:0] rd;
    logic [6:0]  waddr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[4'(i)] = 8'h00;
    m_waddr = 7'd0;
  endtask

  function automatic logic [127:0] m_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f = f | (128'(m_regs[4'(i)]) << (8 * i));
    return f;
  endfunction

  // Byte k of a frame is the k-th most significant byte of fr.
  task automatic model_frame(input logic [31:0] fr, input int n,
                             output logic [31:0] rd, output int strb);
    logic [7:0] cmd, d;
    int a;
    cmd  = 8'(fr >> 24);
    a    = int'(cmd[6:0]);
    rd   = '0;
    strb = 0;
    for (int k = 1; k < n; k++) begin
      d = 8'(fr >> (8 * (3 - k)));
      if (cmd[7]) begin
        if (a < NR) begin
          m_regs[4'(a)] = d;
          strb++;
          m_waddr = 7'(a);
        end
      end else if (a < NR) begin
        rd = rd | (32'(m_regs[4'(a)]) << (8 * (3 - k)));
      end
      if (AUTOINC) a = (a + 1) % 128;
    end
  endtask

  task automatic spi_bits(input logic [7:0] mosi, input int nb, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 0; i < nb; i++) begin
      serial_in = mosi[3'(7 - i)];
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b1;
      miso = {miso[6:0], serial_out};
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < IT + 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("frame_end", 128'(busy), 128'(0));
    repeat (5) @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] fr, input int n,
                           output logic [31:0] rd, output int cyc);
    logic [7:0] m;
    rd = '0;
    for (int k = 0; k < n; k++) begin
      spi_bits(8'(fr >> (8 * (3 - k))), 8, m);
      rd = rd | (32'(m) << (8 * (3 - k)));
    end
    chk("busy_in_frame", 128'(busy), 128'(1));
    wait_idle(cyc);
  endtask

  initial begin
    logic [31:0] rd, m_rd, fr;
    logic [7:0]  junk;
    logic [6:0]  a;
    int          cyc, s0, f0, m_strb, n;

    vecs[0] = '{32'h8077_0000, 2, 1, 0, 8'h77, 0, 8'h77, 32'h0, 7'd0};
    vecs[1] = '{32'h85A5_0000, 2, 1, 5, 8'hA5, 5, 8'hA5, 32'h0, 7'd5};
    vecs[2] = '{32'h863C_0000, 2, 1, 6, 8'h3C, 6, 8'h3C, 32'h0, 7'd6};
`ifdef SPI_REG_TARGET_AUTOINC_EN
    vecs[3] = '{32'h8E11_2233, 4, 2, 14, 8'h11, 15, 8'h22, 32'h0, 7'd15};
    vecs[4] = '{32'h0500_0000, 3, 0, 5, 8'hA5, 6, 8'h3C, 32'h00A5_3C00, 7'd15};
    vecs[5] = '{32'h7F00_0000, 3, 0, 0, 8'h77, 5, 8'hA5, 32'h0000_7700, 7'd15};
`else
    vecs[3] = '{32'h8E11_2233, 4, 3, 14, 8'h33, 15, 8'h00, 32'h0, 7'd14};
    vecs[4] = '{32'h0500_0000, 3, 0, 5, 8'hA5, 6, 8'h3C, 32'h00A5_A500, 7'd14};
    vecs[5] = '{32'h7F00_0000, 3, 0, 0, 8'h77, 5, 8'hA5, 32'h0000_0000, 7'd14};
`endif

    spi_clk = 1'b0;
    serial_in = 1'b0;
    rstn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_regs", 128'(regs_out), 128'(0));
    chk("rst_serial_out", 128'(serial_out), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_wr_strobe", 128'(wr_strobe), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr), 128'(0));
    chk("rst_frame_error", 128'(frame_error), 128'(0));
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      s0 = strobe_cnt;
      f0 = ferr_cnt;
      model_frame(vecs[v].frame, vecs[v].n, m_rd, m_strb);
      run_frame(vecs[v].frame, vecs[v].n, rd, cyc);
      chk("vec_strobes", 128'(strobe_cnt - s0), 128'(vecs[v].strb));
      chk("vec_reg_a", 128'(8'(regs_out >> (8 * vecs[v].c1_idx))), 128'(vecs[v].c1_val));
      chk("vec_reg_b", 128'(8'(regs_out >> (8 * vecs[v].c2_idx))), 128'(vecs[v].c2_val));
      chk("vec_miso", 128'(rd), 128'(vecs[v].rd));
      chk("vec_wr_addr", 128'(wr_addr), 128'(vecs[v].waddr));
      chk("vec_no_ferr", 128'(ferr_cnt - f0), 128'(0));
      chk("vec_idle_time", 128'(cyc >= IT + 1 && cyc <= IT + 5), 128'(1));
      chk("vec_model_regs", 128'(regs_out), m_flat());
    end

    // Partial frame: three bits then silence.
    s0 = strobe_cnt;
    f0 = ferr_cnt;
    spi_bits(8'hA0, 3, junk);
    chk("partial_busy", 128'(busy), 128'(1));
    wait_idle(cyc);
    chk("partial_ferr", 128'(ferr_cnt - f0), 128'(1));
    chk("partial_strobes", 128'(strobe_cnt - s0), 128'(0));
    chk("partial_regs", 128'(regs_out), m_flat());
    model_frame(32'h815A_0000, 2, m_rd, m_strb);
    run_frame(32'h815A_0000, 2, rd, cyc);
    chk("after_partial_reg1", 128'(8'(regs_out >> 8)), 128'(8'h5A));

    // Reset in the middle of a write data byte.
    s0 = strobe_cnt;
    spi_bits(8'h83, 8, junk);
    spi_bits(8'hFF, 5, junk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midwr_rst_regs", 128'(regs_out), 128'(0));
    chk("midwr_rst_serial_out", 128'(serial_out), 128'(0));
    chk("midwr_rst_busy", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("midwr_strobes", 128'(strobe_cnt - s0), 128'(0));
    model_frame(32'h83C3_0000, 2, m_rd, m_strb);
    run_frame(32'h83C3_0000, 2, rd, cyc);
    chk("after_rst_reg3", 128'(regs_out), m_flat());

    // Reset while a read byte is being driven.
    model_frame(32'h85A5_0000, 2, m_rd, m_strb);
    run_frame(32'h85A5_0000, 2, rd, cyc);
    spi_bits(8'h05, 8, junk);
    repeat (5) @(negedge clk);
    chk("midrd_msb", 128'(serial_out), 128'(m_regs[5][7]));
    rstn = 1'b0;
    #1;
    chk("midrd_rst_serial_out", 128'(serial_out), 128'(0));
    chk("midrd_rst_regs", 128'(regs_out), 128'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);

    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 3))
        0:       a = 7'($urandom_range(0, 127));
        1:       a = 7'(126 + $urandom_range(0, 1));
        default: a = 7'($urandom_range(0, NR + 1));
      endcase
      fr = {1'($urandom_range(0, 1)), a, 24'($urandom)};
      n  = int'($urandom_range(1, 4));
      s0 = strobe_cnt;
      f0 = ferr_cnt;
      model_frame(fr, n, m_rd, m_strb);
      run_frame(fr, n, rd, cyc);
      chk("rnd_regs", 128'(regs_out), m_flat());
      chk("rnd_strobes", 128'(strobe_cnt - s0), 128'(m_strb));
      chk("rnd_miso", 128'(rd), 128'(m_rd));
      chk("rnd_wr_addr", 128'(wr_addr), 128'(m_waddr));
      chk("rnd_no_ferr", 128'(ferr_cnt - f0), 128'(0));
      chk("rnd_idle_time", 128'(cyc >= IT + 1 && cyc <= IT + 5), 128'(1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
